// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
//
// Registered writeback stage of the pipelined CPU. On each rising edge it
// captures the MEM-stage instruction. It selects the writeback value from
// five candidate sources and formats sub-word loads. The result is held
// until it has been written to the register file.
//
// Ports
//   cpu_clk, cpu_rst         clock, synchronous active-high reset
//   mem_valid, mem_rf_we     MEM instruction is real / writes the regfile
//   mem_wr                   destination register index
//   mem_wd_sel               source select: 0 imm, 1 alu_c, 2 pc4,
//                            3 formatted dram_rd, 4 csr_rd, 5-7 zero
//   mem_ld_fmt               load format (RISC-V funct3)
//   mem_pc                   instruction PC
//   mem_pc4, mem_imm, mem_alu_c, mem_dram_rd, mem_csr_rd
//                            candidate writeback sources
//   stall, flush             hold the stage / insert a bubble
//   id_rs1, id_rs2           ID-stage source registers for forwarding
//   wb_valid, wb_we, wb_wr, wb_wD, wb_pc
//                            registered writeback state / regfile port
//   fwd_rs1_hit, fwd_rs2_hit WB result must be forwarded to rs1 / rs2
//   instret                  retired-instruction counter (wraps)
//
// DATA_W must be 32: the load formatting works on a 32-bit word.
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              mem_valid,
  input  logic              mem_rf_we,
  input  logic [REG_AW-1:0] mem_wr,
  input  logic [2:0]        mem_wd_sel,
  input  logic [2:0]        mem_ld_fmt,
  input  logic [DATA_W-1:0] mem_pc,
  input  logic [DATA_W-1:0] mem_pc4,
  input  logic [DATA_W-1:0] mem_imm,
  input  logic [DATA_W-1:0] mem_alu_c,
  input  logic [DATA_W-1:0] mem_dram_rd,
  input  logic [DATA_W-1:0] mem_csr_rd,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_wr,
  output logic [DATA_W-1:0] wb_wD,
  output logic [DATA_W-1:0] wb_pc,
  output logic              fwd_rs1_hit,
  output logic              fwd_rs2_hit,
  output logic [CNT_W-1:0]  instret
);

  localparam logic [2:0] SEL_IMM   = 3'd0;
  localparam logic [2:0] SEL_ALU   = 3'd1;
  localparam logic [2:0] SEL_PC4   = 3'd2;
  localparam logic [2:0] SEL_DRAM  = 3'd3;
  localparam logic [2:0] SEL_CSR   = 3'd4;

  localparam logic [2:0] FMT_LB    = 3'b000;
  localparam logic [2:0] FMT_LH    = 3'b001;
  localparam logic [2:0] FMT_LBU   = 3'b100;
  localparam logic [2:0] FMT_LHU   = 3'b101;

  // Pipeline registers
  logic              valid_q,   valid_d;
  logic              rf_we_q,   rf_we_d;
  logic [REG_AW-1:0] wr_q,      wr_d;
  logic [DATA_W-1:0] wd_q,      wd_d;
  logic [DATA_W-1:0] pc_q,      pc_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  // Load formatting intermediates
  logic [1:0]        ld_off;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] sel_data;
  logic              load_valid;

  // Byte/halfword extraction from the loaded word. The byte offset comes
  // from the low address bits, which is the ALU result of the load.
  // Halfwords use only offset bit 1: a misaligned half is read from its
  // aligned half-word.
  always_comb begin
    ld_off  = mem_alu_c[1:0];
    ld_byte = 8'h00;
    case (ld_off)
      2'd0:    ld_byte = mem_dram_rd[7:0];
      2'd1:    ld_byte = mem_dram_rd[15:8];
      2'd2:    ld_byte = mem_dram_rd[23:16];
      default: ld_byte = mem_dram_rd[31:24];
    endcase
    ld_half = ld_off[1] ? mem_dram_rd[31:16] : mem_dram_rd[15:0];

    case (mem_ld_fmt)
      FMT_LB:  ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      FMT_LBU: ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
      FMT_LH:  ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
      FMT_LHU: ld_data = {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_data = mem_dram_rd;
    endcase
  end

  // Writeback source mux. Unused select codes give zero.
  always_comb begin
    case (mem_wd_sel)
      SEL_IMM:  sel_data = mem_imm;
      SEL_ALU:  sel_data = mem_alu_c;
      SEL_PC4:  sel_data = mem_pc4;
      SEL_DRAM: sel_data = ld_data;
      SEL_CSR:  sel_data = mem_csr_rd;
      default:  sel_data = '0;
    endcase
  end

  // Next-state logic. Flush outranks stall. A flushed stage keeps stale
  // data in wr/wd/pc, but valid and rf_we are cleared, so nothing is
  // written or forwarded. rf_we is captured already qualified by
  // mem_valid, so a bubble never carries a write enable.
  always_comb begin
    valid_d    = valid_q;
    rf_we_d    = rf_we_q;
    wr_d       = wr_q;
    wd_d       = wd_q;
    pc_d       = pc_q;
    load_valid = 1'b0;

    if (flush) begin
      valid_d = 1'b0;
      rf_we_d = 1'b0;
    end else if (!stall) begin
      valid_d    = mem_valid;
      rf_we_d    = mem_valid & mem_rf_we;
      wr_d       = mem_wr;
      wd_d       = sel_data;
      pc_d       = mem_pc;
      load_valid = mem_valid;
    end

    // Counts only real instructions that enter WB. It wraps naturally at
    // CNT_W bits. Reset has priority in the flop block, so an instruction
    // present during reset is never counted.
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, load_valid};
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      valid_q   <= 1'b0;
      rf_we_q   <= 1'b0;
      wr_q      <= '0;
      wd_q      <= '0;
      pc_q      <= '0;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      rf_we_q   <= rf_we_d;
      wr_q      <= wr_d;
      wd_q      <= wd_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
    end
  end

  // Writes to x0 are suppressed here, so the register file and the
  // forwarding comparators never see them. Every output below depends
  // only on the pipeline registers and the ID source indices.
  assign wb_valid    = valid_q;
  assign wb_we       = valid_q & rf_we_q & (wr_q != '0);
  assign wb_wr       = wr_q;
  assign wb_wD       = wd_q;
  assign wb_pc       = pc_q;
  assign instret     = instret_q;
  assign fwd_rs1_hit = wb_we & (wr_q == id_rs1);
  assign fwd_rs2_hit = wb_we & (wr_q == id_rs2);

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
//
// Scoreboard bench for wb_stage. Each applied stimulus pushes the expected
// WB state, taken from a small reference model, onto a queue. After the
// capturing edge the entry is popped and compared with the DUT outputs.
// A second instance with CNT_W=4 shares every input and exercises
// counter wrap-around.
// ---------------------------------------------------------------------------
module tb_wb_stage;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        mem_valid, mem_rf_we;
  logic [4:0]  mem_wr;
  logic [2:0]  mem_wd_sel, mem_ld_fmt;
  logic [31:0] mem_pc, mem_pc4, mem_imm, mem_alu_c, mem_dram_rd, mem_csr_rd;
  logic        stall, flush;
  logic [4:0]  id_rs1, id_rs2;

  logic        wb_valid, wb_we, fwd_rs1_hit, fwd_rs2_hit;
  logic [4:0]  wb_wr;
  logic [31:0] wb_wD, wb_pc;
  logic [63:0] instret;

  logic        s_valid, s_we, s_fwd1, s_fwd2;
  logic [4:0]  s_wr;
  logic [31:0] s_wD, s_pc;
  logic [3:0]  s_instret;

  always #5 cpu_clk = ~cpu_clk;

  wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(64)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .mem_valid(mem_valid), .mem_rf_we(mem_rf_we), .mem_wr(mem_wr),
    .mem_wd_sel(mem_wd_sel), .mem_ld_fmt(mem_ld_fmt), .mem_pc(mem_pc),
    .mem_pc4(mem_pc4), .mem_imm(mem_imm), .mem_alu_c(mem_alu_c),
    .mem_dram_rd(mem_dram_rd), .mem_csr_rd(mem_csr_rd),
    .stall(stall), .flush(flush), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_wr(wb_wr), .wb_wD(wb_wD),
    .wb_pc(wb_pc), .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
    .instret(instret)
  );

  wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut_small (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .mem_valid(mem_valid), .mem_rf_we(mem_rf_we), .mem_wr(mem_wr),
    .mem_wd_sel(mem_wd_sel), .mem_ld_fmt(mem_ld_fmt), .mem_pc(mem_pc),
    .mem_pc4(mem_pc4), .mem_imm(mem_imm), .mem_alu_c(mem_alu_c),
    .mem_dram_rd(mem_dram_rd), .mem_csr_rd(mem_csr_rd),
    .stall(stall), .flush(flush), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .wb_valid(s_valid), .wb_we(s_we), .wb_wr(s_wr), .wb_wD(s_wD),
    .wb_pc(s_pc), .fwd_rs1_hit(s_fwd1), .fwd_rs2_hit(s_fwd2),
    .instret(s_instret)
  );

  typedef struct {
    logic        valid;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [63:0] cnt;
    logic [3:0]  cnt4;
    logic        known;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic        m_valid = 1'b0, m_we = 1'b0, m_known = 1'b0;
  logic [4:0]  m_wr = '0;
  logic [31:0] m_wd = '0, m_pc = '0;
  logic [63:0] m_cnt = '0;
  logic [3:0]  m_cnt4 = '0;
  logic [31:0] pc_seed = 32'h0000_1000;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one MEM-stage cycle, advances the model and pushes its result.
  // After the edge it pops that entry and compares it with both DUTs.
  task automatic applyStimulus(input logic rst, input logic valid,
                               input logic rf_we, input logic [4:0] wr,
                               input logic [2:0] sel, input logic [2:0] fmt,
                               input logic [31:0] alu_c, input logic [31:0] dram,
                               input logic [31:0] exp_wd,
                               input logic stl, input logic fl);
    exp_t e;
    cpu_rst     = rst;
    mem_valid   = valid;
    mem_rf_we   = rf_we;
    mem_wr      = wr;
    mem_wd_sel  = sel;
    mem_ld_fmt  = fmt;
    mem_alu_c   = alu_c;
    mem_dram_rd = dram;
    mem_pc      = pc_seed;
    stall       = stl;
    flush       = fl;

    if (rst) begin
      m_valid = 0; m_we = 0; m_wr = '0; m_wd = '0; m_pc = '0;
      m_cnt = '0; m_cnt4 = '0; m_known = 1;
    end else if (fl) begin
      m_valid = 0; m_we = 0; m_known = 0;
    end else if (!stl) begin
      m_valid = valid;
      m_we    = valid & rf_we & (wr != 5'd0);
      m_wr    = wr;
      m_wd    = exp_wd;
      m_pc    = pc_seed;
      m_known = 1;
      if (valid) begin
        m_cnt  = m_cnt + 64'd1;
        m_cnt4 = m_cnt4 + 4'd1;
      end
    end
    e = '{valid: m_valid, we: m_we, wr: m_wr, wd: m_wd, pc: m_pc,
          cnt: m_cnt, cnt4: m_cnt4, known: m_known};
    sb_q.push_back(e);
    pc_seed = pc_seed + 32'd4;

    @(posedge cpu_clk);
    #1;
    e = sb_q.pop_front();
    checkOutput("wb_valid", wb_valid, e.valid);
    checkOutput("wb_we", wb_we, e.we);
    checkOutput("instret", instret, e.cnt);
    checkOutput("fwd_rs1", fwd_rs1_hit, e.we & (e.wr == id_rs1));
    checkOutput("fwd_rs2", fwd_rs2_hit, e.we & (e.wr == id_rs2));
    checkOutput("s_valid", s_valid, e.valid);
    checkOutput("s_we", s_we, e.we);
    checkOutput("s_instret", s_instret, e.cnt4);
    checkOutput("s_fwd1", s_fwd1, e.we & (e.wr == id_rs1));
    checkOutput("s_fwd2", s_fwd2, e.we & (e.wr == id_rs2));
    if (e.known) begin
      checkOutput("wb_wr", wb_wr, e.wr);
      checkOutput("wb_wD", wb_wD, e.wd);
      checkOutput("wb_pc", wb_pc, e.pc);
      checkOutput("s_wr", s_wr, e.wr);
      checkOutput("s_wD", s_wD, e.wd);
      checkOutput("s_pc", s_pc, e.pc);
    end
  endtask

  logic [31:0] load_word;
  logic [2:0]  rnd_sel;
  logic [31:0] rnd_exp;

  initial begin
    cpu_rst = 1; mem_valid = 0; mem_rf_we = 0; mem_wr = '0;
    mem_wd_sel = '0; mem_ld_fmt = 3'b010; mem_pc = '0;
    mem_imm = 32'h11; mem_pc4 = 32'h33; mem_csr_rd = 32'h55;
    mem_alu_c = 32'h22; mem_dram_rd = 32'h44;
    stall = 0; flush = 0; id_rs1 = '0; id_rs2 = '0;

    // Reset for two cycles with junk on the MEM inputs
    applyStimulus(1, 1, 1, 5'd5, 3'd1, 3'b010, 32'h22, 32'h44, 32'h0, 1, 0);
    applyStimulus(1, 1, 1, 5'd5, 3'd1, 3'b010, 32'h22, 32'h44, 32'h0, 0, 1);

    // All five sources plus an unused select code
    applyStimulus(0, 1, 1, 5'd5, 3'd0, 3'b010, 32'h22, 32'h44, 32'h11, 0, 0);
    applyStimulus(0, 1, 1, 5'd5, 3'd1, 3'b010, 32'h22, 32'h44, 32'h22, 0, 0);
    applyStimulus(0, 1, 1, 5'd5, 3'd2, 3'b010, 32'h22, 32'h44, 32'h33, 0, 0);
    applyStimulus(0, 1, 1, 5'd5, 3'd3, 3'b010, 32'h22, 32'h44, 32'h44, 0, 0);
    applyStimulus(0, 1, 1, 5'd5, 3'd4, 3'b010, 32'h22, 32'h44, 32'h55, 0, 0);
    checkOutput("instret_after_sources", instret, 64'd5);
    applyStimulus(0, 1, 1, 5'd5, 3'd6, 3'b010, 32'h22, 32'h44, 32'h0, 0, 0);

    // Load formats
    load_word = 32'h80FF7F01;
    applyStimulus(0, 1, 1, 5'd6, 3'd3, 3'b000, 32'h3, load_word, 32'hFFFFFF80, 0, 0);
    applyStimulus(0, 1, 1, 5'd6, 3'd3, 3'b100, 32'h3, load_word, 32'h00000080, 0, 0);
    applyStimulus(0, 1, 1, 5'd6, 3'd3, 3'b000, 32'h1, load_word, 32'h0000007F, 0, 0);
    applyStimulus(0, 1, 1, 5'd6, 3'd3, 3'b001, 32'h2, load_word, 32'hFFFF80FF, 0, 0);
    applyStimulus(0, 1, 1, 5'd6, 3'd3, 3'b101, 32'h0, load_word, 32'h00007F01, 0, 0);
    applyStimulus(0, 1, 1, 5'd6, 3'd3, 3'b010, 32'h1, load_word, 32'h80FF7F01, 0, 0);
    applyStimulus(0, 1, 1, 5'd6, 3'd3, 3'b001, 32'h3, load_word, 32'hFFFF80FF, 0, 0);
    applyStimulus(0, 1, 1, 5'd6, 3'd3, 3'b101, 32'h2, load_word, 32'h000080FF, 0, 0);
    applyStimulus(0, 1, 1, 5'd6, 3'd3, 3'b100, 32'h2, load_word, 32'h000000FF, 0, 0);
    applyStimulus(0, 1, 1, 5'd6, 3'd3, 3'b011, 32'h3, load_word, 32'h80FF7F01, 0, 0);

    // Write to x0 is suppressed but still retires
    id_rs1 = 5'd0; id_rs2 = 5'd0;
    applyStimulus(0, 1, 1, 5'd0, 3'd0, 3'b010, 32'h22, 32'h44, 32'h11, 0, 0);
    checkOutput("x0_we", wb_we, 1'b0);
    checkOutput("x0_fwd1", fwd_rs1_hit, 1'b0);

    // Stall holds instruction A while B waits; then stall+flush bubbles
    applyStimulus(0, 1, 1, 5'd7, 3'd0, 3'b010, 32'h22, 32'h44, 32'h11, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 1, 5'd8, 3'd1, 3'b010, 32'h22, 32'h44, 32'h22, 1, 0);
    checkOutput("stall_wr", wb_wr, 5'd7);
    applyStimulus(0, 1, 1, 5'd8, 3'd1, 3'b010, 32'h22, 32'h44, 32'h22, 1, 1);
    checkOutput("flush_valid", wb_valid, 1'b0);
    applyStimulus(0, 0, 1, 5'd8, 3'd1, 3'b010, 32'h22, 32'h44, 32'h22, 0, 0);

    // Forwarding hits, then cleared by a bubble
    id_rs1 = 5'd9; id_rs2 = 5'd3;
    applyStimulus(0, 1, 1, 5'd9, 3'd1, 3'b010, 32'h22, 32'h44, 32'h22, 0, 0);
    checkOutput("fwd1_hit", fwd_rs1_hit, 1'b1);
    checkOutput("fwd2_miss", fwd_rs2_hit, 1'b0);
    applyStimulus(0, 0, 1, 5'd9, 3'd1, 3'b010, 32'h22, 32'h44, 32'h22, 0, 0);
    checkOutput("bubble_fwd1", fwd_rs1_hit, 1'b0);

    // Reset in the middle of a valid capture is not counted
    applyStimulus(1, 1, 1, 5'd4, 3'd0, 3'b010, 32'h22, 32'h44, 32'h11, 0, 0);

    // Counter wrap on the 4-bit instance: 17 captures -> 1
    for (int i = 0; i < 17; i++)
      applyStimulus(0, 1, 1, 5'd2, 3'd2, 3'b010, 32'h22, 32'h44, 32'h33, 0, 0);
    checkOutput("wrap_small", s_instret, 4'd1);
    checkOutput("wrap_big", instret, 64'd17);
    applyStimulus(1, 1, 1, 5'd2, 3'd2, 3'b010, 32'h22, 32'h44, 32'h33, 0, 0);
    checkOutput("rst_small", s_instret, 4'd0);

    // Random mix of stalls, flushes and bubbles
    for (int i = 0; i < 40; i++) begin
      id_rs1 = 5'($urandom_range(0, 7));
      id_rs2 = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       begin rnd_sel = 3'd0; rnd_exp = 32'h11; end
        1:       begin rnd_sel = 3'd1; rnd_exp = 32'h22; end
        2:       begin rnd_sel = 3'd2; rnd_exp = 32'h33; end
        default: begin rnd_sel = 3'd4; rnd_exp = 32'h55; end
      endcase
      applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), rnd_sel, 3'b010, 32'h22, 32'h44,
                    rnd_exp, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
